// File: rtl/regex_imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among N_CPU regex_cpu instances.
// One transaction in flight at a time: GRANT holds the request until mem_ready, DATA forwards the word.
module regex_imem_arbiter #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int ID_WIDTH          = $clog2(N_CPU)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CPU-1:0]                   cpu_memory_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
  output logic [N_CPU-1:0]                   cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]            cpu_memory_data,
  output logic                               mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
  input  logic                               mem_ready,
  input  logic [MEMORY_WIDTH-1:0]            mem_data,
  output logic [ID_WIDTH-1:0]                grant_id,
  output logic                               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [ID_WIDTH-1:0]          r_rr_ptr;
  logic [ID_WIDTH-1:0]          r_owner;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr_q;
  logic                         r_mem_valid;

  logic [N_CPU-1:0]             w_cand;
  logic [ID_WIDTH-1:0]          w_idx;
  logic [ID_WIDTH-1:0]          w_win;
  logic [ID_WIDTH-1:0]          w_rr_nxt;
  logic                         w_found;
  logic                         w_take;
  logic [MEMORY_ADDR_WIDTH-1:0] w_win_addr;

  // The owner just served still has valid high during DATA; keep it out of the next round.
  always_comb begin
    w_cand = cpu_memory_valid;
    if (r_state == S_DATA) begin
      w_cand[r_owner] = 1'b0;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_CPU; k++) begin
      w_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % N_CPU);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_addr = cpu_memory_addr[int'(w_win)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  assign w_rr_nxt   = (int'(w_win) == N_CPU - 1) ? '0 : w_win + 1'b1;
  assign w_take     = w_found && ((r_state == S_IDLE) || (r_state == S_DATA));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: if (mem_ready) w_state_nxt = S_DATA;
      S_DATA:  w_state_nxt = w_found ? S_GRANT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_addr_q    <= '0;
      r_mem_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_valid <= (w_state_nxt == S_GRANT);
      if (w_take) begin
        r_owner  <= w_win;
        r_addr_q <= w_win_addr;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // Ready is a combinational echo of mem_ready, steered to the latched owner only.
  always_comb begin
    cpu_memory_ready = '0;
    if ((r_state == S_GRANT) && mem_ready) begin
      cpu_memory_ready[r_owner] = 1'b1;
    end
  end

  assign cpu_memory_data = mem_data;
  assign mem_valid       = r_mem_valid;
  assign mem_addr        = r_addr_q;
  assign grant_id        = r_owner;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_regex_imem_arbiter.sv
// Self-checking bench for regex_imem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_regex_imem_arbiter;
  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 11;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cpu_memory_valid;
  logic [N*AW-1:0] cpu_memory_addr;
  logic [N-1:0]    cpu_memory_ready;
  logic [MW-1:0]   cpu_memory_data;
  logic            mem_valid;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic [MW-1:0]   mem_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  regex_imem_arbiter #(
    .N_CPU(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_memory_valid(cpu_memory_valid), .cpu_memory_addr(cpu_memory_addr),
    .cpu_memory_ready(cpu_memory_ready), .cpu_memory_data(cpu_memory_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit auto_mem = 1'b0;
  bit hs;
  logic [AW-1:0] hs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] hash(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 16'h3C5A;
  endfunction

  // Reference model: one transaction record (active, accepted-by-memory), owner, address, pointer.
  bit            m_active = 1'b0;
  bit            m_resp   = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  logic [AW-1:0] m_addr   = '0;

  function automatic int pick(input logic [N-1:0] v, input int ptr, input bit mask, input int own);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
    foreach (order[j]) begin
      if (v[order[j]] && !(mask && order[j] == own)) return order[j];
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_active = 1'b0; m_resp = 1'b0; m_owner = 0; m_ptr = 0; m_addr = '0;
    end else if (m_active && !m_resp) begin
      if (mem_ready) m_resp = 1'b1;
    end else begin
      w = pick(cpu_memory_valid, m_ptr, m_resp, m_owner);
      if (w >= 0) begin
        m_active = 1'b1; m_resp = 1'b0; m_owner = w;
        m_addr = cpu_memory_addr[w*AW +: AW];
        m_ptr = (w + 1) % N;
      end else begin
        m_active = 1'b0; m_resp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_valid", mem_valid, (m_active && !m_resp));
      chk("mem_addr", mem_addr, m_addr);
      chk("busy", busy, m_active);
      chk("grant_id", grant_id, m_owner);
      chk("ready", cpu_memory_ready, (m_active && !m_resp && mem_ready) ? (1 << m_owner) : 0);
      chk("data_pass", cpu_memory_data, mem_data);
      if (auto_mem && m_active && m_resp) chk("data_owner", cpu_memory_data, hash(m_addr));
    end
  end

  task automatic step();
    #3;
    hs      = mem_valid && mem_ready;
    hs_addr = mem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) mem_data = hs ? hash(hs_addr) : MW'($urandom);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    cpu_memory_addr[i*AW +: AW] = a;
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};
  logic [AW-1:0] rr_addr[4] = '{11'h010, 11'h020, 11'h030, 11'h040};

  initial begin
    rst = 1'b1; cpu_memory_valid = '0; cpu_memory_addr = '0; mem_ready = 1'b0; mem_data = '0;
    step();
    chk_en = 1'b1;
    step();
    settle();
    chk("rst_mv", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;

    // Single requester: CPU2 at 0x05A
    cpu_memory_valid = 4'b0100; set_addr(2, 11'h05A);
    settle(); chk("t1_idle_mv", mem_valid, 0); step();
    settle(); chk("t1_mv", mem_valid, 1); chk("t1_addr", mem_addr, 11'h05A);
    chk("t1_noready", cpu_memory_ready, 0); step();
    mem_ready = 1'b1;
    settle(); chk("t1_ready", cpu_memory_ready, 4'b0100); step();
    cpu_memory_valid = '0; mem_ready = 1'b0; mem_data = 16'h1234;
    settle(); chk("t1_data", cpu_memory_data, 16'h1234); chk("t1_mv_data", mem_valid, 0);
    chk("t1_ready_off", cpu_memory_ready, 0); step();
    settle(); chk("t1_busy_idle", busy, 0); chk("t1_gid", grant_id, 2); step();

    // Owner masking: CPU1 holds valid through its DATA cycle
    cpu_memory_valid = 4'b0010; set_addr(1, 11'h123); step();
    mem_ready = 1'b1;
    settle(); chk("m_ready", cpu_memory_ready, 4'b0010); step();
    mem_ready = 1'b0;
    settle(); chk("m_mv_data", mem_valid, 0); step();
    cpu_memory_valid = '0;
    settle(); chk("m_busy", busy, 0); chk("m_gid", grant_id, 1); chk("m_mv", mem_valid, 0); step();

    // Memory stall: CPU3 at 0x7FF, CPU0 arrives mid-stall
    cpu_memory_valid = 4'b1000; set_addr(3, 11'h7FF); step();
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin cpu_memory_valid = 4'b1001; set_addr(0, 11'h111); end
      settle(); chk("s_mv", mem_valid, 1); chk("s_addr", mem_addr, 11'h7FF);
      chk("s_noready", cpu_memory_ready, 0); step();
    end
    mem_ready = 1'b1;
    settle(); chk("s_ready", cpu_memory_ready, 4'b1000); step();
    cpu_memory_valid = 4'b0001; mem_ready = 1'b0;
    settle(); chk("s_mv_data", mem_valid, 0); step();
    mem_ready = 1'b1;
    settle(); chk("s_gid0", grant_id, 0); chk("s_addr0", mem_addr, 11'h111);
    chk("s_ready0", cpu_memory_ready, 4'b0001); step();
    cpu_memory_valid = '0; mem_ready = 1'b0; step();

    // Wrap-around: serve CPU2 (pointer -> 3), then CPU0 and CPU3 together
    cpu_memory_valid = 4'b0100; set_addr(2, 11'h222); step();
    mem_ready = 1'b1;
    settle(); chk("w_ready2", cpu_memory_ready, 4'b0100); step();
    cpu_memory_valid = 4'b1001; set_addr(3, 11'h333); set_addr(0, 11'h044); mem_ready = 1'b0; step();
    mem_ready = 1'b1;
    settle(); chk("w_gid3", grant_id, 3); chk("w_ready3", cpu_memory_ready, 4'b1000);
    chk("w_addr3", mem_addr, 11'h333); step();
    cpu_memory_valid = 4'b0001; mem_ready = 1'b0; step();
    mem_ready = 1'b1;
    settle(); chk("w_gid0", grant_id, 0); chk("w_ready0", cpu_memory_ready, 4'b0001);
    chk("w_addr0", mem_addr, 11'h044); step();
    cpu_memory_valid = '0; mem_ready = 1'b0; step();

    // Round-robin: all four hold valid from reset, zero-wait memory
    auto_mem = 1'b1; rst = 1'b1; cpu_memory_valid = 4'b1111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, rr_addr[i]);
    step(); step();
    rst = 1'b0;
    for (int r = 0; r < 10; r++) begin
      settle();
      if (r == 0) chk("rr_mv_idle", mem_valid, 0);
      else if (r % 2 == 1) begin
        chk("rr_mv_grant", mem_valid, 1);
        chk("rr_ready", cpu_memory_ready, 1 << exp_seq[(r - 1) / 2]);
        chk("rr_addr", mem_addr, rr_addr[exp_seq[(r - 1) / 2]]);
      end else begin
        chk("rr_mv_data", mem_valid, 0);
        chk("rr_data", cpu_memory_data, hash(rr_addr[exp_seq[(r - 2) / 2]]));
      end
      step();
    end
    cpu_memory_valid = '0; mem_ready = 1'b0; step(); step();

    // Reset during GRANT with memory never ready
    cpu_memory_valid = 4'b0100; set_addr(2, 11'h0AB); step();
    rst = 1'b1;
    settle(); chk("x_mv_pre", mem_valid, 1); step();
    rst = 1'b0; cpu_memory_valid = 4'b0110; set_addr(1, 11'h0CD); mem_ready = 1'b1;
    settle(); chk("x_mv", mem_valid, 0); chk("x_busy", busy, 0);
    chk("x_ready", cpu_memory_ready, 0); step();
    mem_ready = 1'b0;
    settle(); chk("x_gid1", grant_id, 1); chk("x_addr1", mem_addr, 11'h0CD); step();
    mem_ready = 1'b1;
    settle(); chk("x_ready1", cpu_memory_ready, 4'b0010); step();
    cpu_memory_valid = '0; mem_ready = 1'b0; step(); step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      cpu_memory_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) set_addr(i, AW'($urandom));
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regex_imem_arbiter.md
Name: regex_imem_arbiter

Overview:
- Shares one instruction-memory read port between N_CPU regex_cpu instances.
- Each CPU-side port uses the same memory handshake regex_cpu already uses: request valid/addr, ready pulse, data the following cycle.
- Round-robin arbitration; one outstanding transaction at a time.
- Sits between the regex_cpu array and the instruction BRAM/memory controller.

Parameters:
- N_CPU, 4, number of requesting regex_cpu instances (2..16).
- MEMORY_WIDTH, 16, instruction word width.
- MEMORY_ADDR_WIDTH, 11, instruction address width.
- ID_WIDTH, $clog2(N_CPU), width of owner index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_memory_valid  in  N_CPU  per-CPU read request; bit i = CPU i.
- cpu_memory_addr  in  N_CPU*MEMORY_ADDR_WIDTH  per-CPU address; slice i = CPU i.
- cpu_memory_ready  out  N_CPU  per-CPU accept pulse; one-hot or zero.
- cpu_memory_data  out  MEMORY_WIDTH  broadcast read data; valid for the owner the cycle after its ready.
- mem_valid  out  1  request to memory.
- mem_addr  out  MEMORY_ADDR_WIDTH  address to memory.
- mem_ready  in  1  memory accepts request; mem_data valid next cycle.
- mem_data  in  MEMORY_WIDTH  memory read data.
- grant_id  out  ID_WIDTH  current/last owner index (debug).
- busy  out  1  high in GRANT and DATA states.

Behaviour:
- States:
  - IDLE: no transaction.
  - GRANT: owner latched; mem_valid high.
  - DATA: one-cycle response forwarding.
- Reset values: state=IDLE, rr_ptr=0, owner=0, addr_q=0, mem_valid=0, mem_addr=0, cpu_memory_ready=0, grant_id=0, busy=0.
- Arbitration (IDLE, or DATA with candidates): winner = first i with cpu_memory_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, N_CPU-1, wrapping to 0.
  - On win: owner<=i, addr_q<=addr slice i, state<=GRANT.
  - rr_ptr<=(i+1) mod N_CPU; wraps from N_CPU-1 to 0.
- In DATA, the just-served owner is masked from arbitration: its valid is still high that cycle.
- GRANT:
  - mem_valid=1 and mem_addr=addr_q, both registered (stable for the whole GRANT).
  - cpu_memory_ready[owner]=mem_ready, combinational; all other bits 0.
  - mem_ready=1 -> state<=DATA. mem_ready=0 -> stay; any wait length allowed.
- DATA:
  - cpu_memory_data=mem_data, combinational pass-through; the owner samples it this cycle.
  - mem_valid=0.
  - Unmasked request pending -> GRANT for the new owner next cycle; else IDLE.
- cpu_memory_data is driven as mem_data in all states; non-owners ignore it.
- Latency:
  - Request seen in IDLE at cycle t -> mem_valid at t+1.
  - mem_ready at t+1 -> cpu_memory_ready[i] at t+1, data at t+2.
  - Back-to-back throughput: one transaction per 2 cycles (GRANT, DATA) with zero-wait memory.
- Owner drops cpu_memory_valid while in GRANT (protocol violation): transaction still completes on latched addr_q; ready still pulses to that index.
- Address changes from a waiting (non-owner) CPU: only the value present when it wins arbitration is captured.
- Simultaneous requests from all CPUs: served in strict rotation starting at rr_ptr; no CPU waits more than N_CPU-1 transactions.
- rst asserted in any state: next cycle IDLE, mem_valid=0, rr_ptr=0. An in-flight mem_data is discarded; no ready is issued after reset.
- mem_ready while not in GRANT: ignored.
- Invariant: cpu_memory_ready is at most one-hot and only nonzero in GRANT with mem_ready=1.

Test Plan:
- Single requester: CPU2 requests addr 0x05A, memory ready 1 cycle after mem_valid -> mem_addr=0x05A; cpu_memory_ready=4'b0100 for exactly 1 cycle; cpu_memory_data=0x1234 the next cycle; mem_valid low in the DATA cycle; return to IDLE.
- Round-robin fairness: all 4 CPUs hold valid (addrs 0x010,0x020,0x030,0x040) from reset; zero-wait memory -> grants in order 0,1,2,3,0; mem_valid pattern 1,0,1,0…; each CPU receives its own address's data.
- Owner masking: CPU1 alone, its valid held one extra cycle after ready -> no second grant to CPU1 from the DATA cycle; grant_id stays 1; arbiter enters IDLE.
- Memory stall: CPU3 requests 0x7FF, mem_ready delayed 5 cycles -> mem_valid/mem_addr stable all 5 cycles; no ready to any CPU until mem_ready; CPU0 request arriving mid-stall is granted next.
- Wrap-around: rr_ptr=3 after serving CPU2; CPU0 and CPU3 request together -> CPU3 wins first, then CPU0.
- Reset mid-transaction: rst in GRANT with mem_ready never given -> next cycle mem_valid=0, busy=0, cpu_memory_ready=0; after release, CPU1 and CPU2 both request -> CPU1 granted first (rr_ptr=0).
